// File: rtl/cpu.sv
// Byte-addressed 8-bit CPU with a two-byte fetch, a 16x12 return stack and
// multi-cycle block-transfer and BCD instructions over one synchronous memory.
module cpu (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] pc
);

  localparam logic [2:0] STATE_FETCH_HI = 3'd0;
  localparam logic [2:0] STATE_FETCH_LO = 3'd1;
  localparam logic [2:0] STATE_EXECUTE  = 3'd2;
  localparam logic [2:0] STATE_STORE    = 3'd3;
  localparam logic [2:0] STATE_LOAD     = 3'd4;
  localparam logic [2:0] STATE_BCD      = 3'd5;
  localparam logic [2:0] STATE_IDLE     = 3'd6;

  logic [2:0]  state;
  logic [7:0]  _mem [4096];
  logic [7:0]  v [16];
  logic [11:0] addr;
  logic [11:0] stack_q [16];
  logic [3:0]  sp_q;
  logic [3:0]  idx_q;
  logic [7:0]  ir_hi_q;
  logic [7:0]  rdata_q;

  logic [15:0] instr;
  logic [3:0]  op, x, y, n;
  logic [7:0]  nn, vx, vy;
  logic [11:0] nnn;

  assign instr = {ir_hi_q, rdata_q};
  assign op    = instr[15:12];
  assign x     = instr[11:8];
  assign y     = instr[7:4];
  assign n     = instr[3:0];
  assign nn    = instr[7:0];
  assign nnn   = instr[11:0];
  assign vx    = v[x];
  assign vy    = v[y];

  logic [8:0] sum;
  logic [7:0] alu_r;
  logic       alu_f, alu_wf, alu_ok;

  always_comb begin
    sum    = {1'b0, vx} + {1'b0, vy};
    alu_r  = vy;
    alu_f  = 1'b0;
    alu_wf = 1'b0;
    alu_ok = 1'b1;
    case (n)
      4'h0: alu_r = vy;
      4'h1: alu_r = vx | vy;
      4'h2: alu_r = vx & vy;
      4'h3: alu_r = vx ^ vy;
      4'h4: begin
        alu_r  = sum[7:0];
        alu_f  = sum[8];
        alu_wf = 1'b1;
      end
      4'h5: begin
        alu_r  = vx - vy;
        alu_f  = vx >= vy;
        alu_wf = 1'b1;
      end
      4'h6: begin
        alu_r  = {1'b0, vx[7:1]};
        alu_f  = vx[0];
        alu_wf = 1'b1;
      end
      4'h7: begin
        alu_r  = vy - vx;
        alu_f  = vy >= vx;
        alu_wf = 1'b1;
      end
      4'hE: begin
        alu_r  = {vx[6:0], 1'b0};
        alu_f  = vx[7];
        alu_wf = 1'b1;
      end
      default: alu_ok = 1'b0;
    endcase
  end

  logic [7:0] bcd;

  always_comb begin
    case (idx_q[1:0])
      2'd0:    bcd = vx / 8'd100;
      2'd1:    bcd = (vx / 8'd10) % 8'd10;
      default: bcd = vx % 8'd10;
    endcase
  end

  logic [11:0] raddr, waddr;
  logic [7:0]  wdata;
  logic        mem_we;

  // Writes are gated by reset so an aborted transfer stops immediately.
  always_comb begin
    raddr  = pc;
    mem_we = 1'b0;
    waddr  = addr + 12'(idx_q);
    wdata  = v[idx_q];
    case (state)
      STATE_FETCH_LO: raddr = pc + 12'd1;
      STATE_EXECUTE: begin
        if (op == 4'hF && nn == 8'h65) raddr = addr;
      end
      STATE_LOAD:  raddr = addr + 12'(idx_q) + 12'd1;
      STATE_STORE: mem_we = !reset;
      STATE_BCD: begin
        mem_we = !reset;
        wdata  = bcd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) _mem[waddr] <= wdata;
    rdata_q <= _mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= 12'h200;
      state <= STATE_FETCH_HI;
      sp_q  <= 4'd0;
      addr  <= 12'd0;
      idx_q <= 4'd0;
      for (int i = 0; i < 16; i++) v[i] <= 8'd0;
    end else begin
      case (state)
        STATE_FETCH_HI: state <= STATE_FETCH_LO;
        STATE_FETCH_LO: begin
          ir_hi_q <= rdata_q;
          state   <= STATE_EXECUTE;
        end
        STATE_EXECUTE: begin
          state <= STATE_FETCH_HI;
          pc    <= pc + 12'd2;
          idx_q <= 4'd0;
          case (op)
            4'h0: begin
              if (instr == 16'h0000) begin
                state <= STATE_IDLE;
                pc    <= pc;
              end else if (instr == 16'h00EE) begin
                sp_q <= sp_q - 4'd1;
                pc   <= stack_q[sp_q - 4'd1];
              end
            end
            4'h1: begin
              pc <= nnn;
              if (nnn == pc) state <= STATE_IDLE;
            end
            4'h2: begin
              stack_q[sp_q] <= pc + 12'd2;
              sp_q          <= sp_q + 4'd1;
              pc            <= nnn;
            end
            4'h3: if (vx == nn) pc <= pc + 12'd4;
            4'h4: if (vx != nn) pc <= pc + 12'd4;
            4'h5: if (n == 4'h0 && vx == vy) pc <= pc + 12'd4;
            4'h9: if (n == 4'h0 && vx != vy) pc <= pc + 12'd4;
            4'h6: v[x] <= nn;
            4'h7: v[x] <= vx + nn;
            4'h8: begin
              // VF written last so the flag wins when X is F.
              if (alu_ok) v[x] <= alu_r;
              if (alu_ok && alu_wf) v[15] <= {7'd0, alu_f};
            end
            4'hA: addr <= nnn;
            4'hB: pc <= nnn + {4'h0, v[0]};
            4'hF: begin
              case (nn)
                8'h1E: addr <= addr + 12'(vx);
                8'h33: state <= STATE_BCD;
                8'h55: state <= STATE_STORE;
                8'h65: state <= STATE_LOAD;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        STATE_STORE: begin
          if (idx_q == x) state <= STATE_FETCH_HI;
          else idx_q <= idx_q + 4'd1;
        end
        STATE_LOAD: begin
          v[idx_q] <= rdata_q;
          if (idx_q == x) state <= STATE_FETCH_HI;
          else idx_q <= idx_q + 4'd1;
        end
        STATE_BCD: begin
          if (idx_q == 4'd2) state <= STATE_FETCH_HI;
          else idx_q <= idx_q + 4'd1;
        end
        STATE_IDLE: ;
        default: state <= STATE_FETCH_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: preloads programs into memory, runs to idle and
// checks registers, memory and pc with immediate assertions.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc;

  int n_asrt = 0;
  int n_fail = 0;

  cpu dut (
    .clk   (clk),
    .reset (reset),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_prog();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) dut._mem[i] = 8'h00;
  endtask

  task automatic put(input int a, input logic [15:0] ins);
    dut._mem[a]     = ins[15:8];
    dut._mem[a + 1] = ins[7:0];
  endtask

  task automatic go();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s);
    int k = 0;
    while (dut.state !== s && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(dut.state), 32'(s));
  endtask

  initial begin
    // Reset clears registers that were dirtied beforehand
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dut.v[3] = 8'h55;
    dut.v[15] = 8'h99;
    dut.addr = 12'h123;
    dut.pc = 12'h444;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h200);
    chk("rst_state", 32'(dut.state), 32'(dut.STATE_FETCH_HI));
    chk("rst_v3", 32'(dut.v[3]), 32'h0);
    chk("rst_vf", 32'(dut.v[15]), 32'h0);
    chk("rst_addr", 32'(dut.addr), 32'h0);

    // Jump-to-self
    begin_prog();
    put(12'h200, 16'h6042);
    put(12'h202, 16'h1206);
    put(12'h204, 16'h6000);
    put(12'h206, 16'h1206);
    go();
    wait_state("jmp_idle", dut.STATE_IDLE);
    chk("jmp_v0", 32'(dut.v[0]), 32'h42);
    chk("jmp_pc", 32'(pc), 32'h206);
    repeat (3) @(negedge clk);
    chk("idle_hold_pc", 32'(pc), 32'h206);

    // Call / return
    begin_prog();
    put(12'h200, 16'h2206);
    put(12'h206, 16'h6042);
    put(12'h208, 16'h00EE);
    go();
    wait_state("call_idle", dut.STATE_IDLE);
    chk("call_pc", 32'(pc), 32'h202);
    chk("call_v0", 32'(dut.v[0]), 32'h42);

    // 8XY4 without carry
    begin_prog();
    put(12'h200, 16'h6030);
    put(12'h202, 16'h6112);
    put(12'h204, 16'h8014);
    go();
    wait_state("add_idle", dut.STATE_IDLE);
    chk("add_v0", 32'(dut.v[0]), 32'h42);
    chk("add_vf", 32'(dut.v[15]), 32'h0);

    // 7XNN wraps and leaves VF alone
    begin_prog();
    put(12'h200, 16'h6F07);
    put(12'h202, 16'h60FF);
    put(12'h204, 16'h7043);
    go();
    wait_state("addi_idle", dut.STATE_IDLE);
    chk("addi_v0", 32'(dut.v[0]), 32'h42);
    chk("addi_vf", 32'(dut.v[15]), 32'h07);

    // Carry, borrow, shift, flag-wins on X=F
    begin_prog();
    put(12'h200, 16'h60F0);
    put(12'h202, 16'h6120);
    put(12'h204, 16'h8014);
    put(12'h206, 16'h6205);
    put(12'h208, 16'h6307);
    put(12'h20A, 16'h8235);
    put(12'h20C, 16'h6481);
    put(12'h20E, 16'h8406);
    put(12'h210, 16'h6FFF);
    put(12'h212, 16'h6501);
    put(12'h214, 16'h8F54);
    go();
    wait_state("alu_idle", dut.STATE_IDLE);
    chk("carry_v0", 32'(dut.v[0]), 32'h10);
    chk("sub_v2", 32'(dut.v[2]), 32'hFE);
    chk("shr_v4", 32'(dut.v[4]), 32'h40);
    chk("flagwins_vf", 32'(dut.v[15]), 32'h01);

    // Skip taken and not-taken
    begin_prog();
    put(12'h200, 16'h6005);
    put(12'h202, 16'h3005);
    put(12'h204, 16'h6011);
    put(12'h206, 16'h6122);
    put(12'h208, 16'h4105);
    put(12'h20A, 16'h6277);
    put(12'h20C, 16'h6388);
    go();
    wait_state("skip_idle", dut.STATE_IDLE);
    chk("skip_v0", 32'(dut.v[0]), 32'h05);
    chk("skip_v1", 32'(dut.v[1]), 32'h22);
    chk("skip_v2", 32'(dut.v[2]), 32'h00);
    chk("skip_pc", 32'(pc), 32'h20E);

    // Store / load round trip
    begin_prog();
    put(12'h200, 16'hA300);
    put(12'h202, 16'h6042);
    put(12'h204, 16'hF055);
    put(12'h206, 16'h6000);
    put(12'h208, 16'hF065);
    go();
    wait_state("mem_idle", dut.STATE_IDLE);
    chk("mem_300", 32'(dut._mem[12'h300]), 32'h42);
    chk("mem_v0", 32'(dut.v[0]), 32'h42);
    chk("mem_addr", 32'(dut.addr), 32'h300);

    // Multi-byte load
    begin_prog();
    put(12'h200, 16'hA310);
    put(12'h202, 16'hF265);
    dut._mem[12'h310] = 8'hA1;
    dut._mem[12'h311] = 8'hB2;
    dut._mem[12'h312] = 8'hC3;
    dut._mem[12'h313] = 8'hD4;
    go();
    wait_state("ld3_idle", dut.STATE_IDLE);
    chk("ld3_v0", 32'(dut.v[0]), 32'hA1);
    chk("ld3_v1", 32'(dut.v[1]), 32'hB2);
    chk("ld3_v2", 32'(dut.v[2]), 32'hC3);
    chk("ld3_v3", 32'(dut.v[3]), 32'h00);

    // BCD
    begin_prog();
    put(12'h200, 16'h60FE);
    put(12'h202, 16'hA300);
    put(12'h204, 16'hF033);
    go();
    wait_state("bcd_idle", dut.STATE_IDLE);
    chk("bcd_h", 32'(dut._mem[12'h300]), 32'h02);
    chk("bcd_t", 32'(dut._mem[12'h301]), 32'h05);
    chk("bcd_o", 32'(dut._mem[12'h302]), 32'h04);
    chk("bcd_addr", 32'(dut.addr), 32'h300);

    // Reset in the middle of F355
    begin_prog();
    put(12'h200, 16'h6011);
    put(12'h202, 16'h6122);
    put(12'h204, 16'h6233);
    put(12'h206, 16'h6344);
    put(12'h208, 16'hA300);
    put(12'h20A, 16'hF355);
    go();
    wait_state("abort_store", dut.STATE_STORE);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_pc", 32'(pc), 32'h200);
    chk("abort_state", 32'(dut.state), 32'(dut.STATE_FETCH_HI));
    for (int i = 0; i < 4; i++) chk($sformatf("abort_v%0d", i), 32'(dut.v[i]), 32'h0);
    chk("abort_mem300", 32'(dut._mem[12'h300]), 32'h11);
    chk("abort_mem301", 32'(dut._mem[12'h301]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
